router_1x3_top: RTL and testbench
=================================

// Module: router_1x3_top
// PURPOSE
// 1-input, 3-output byte packet router. Accepts packets {header, payload..., parity} on data_in,
// buffers each packet into one of three output FIFOs chosen by header[1:0], and exposes each FIFO
// through a read-enable/valid port. Checks packet parity; throttles the source with busy.
// PARAMETERS
// DATA_WIDTH  8   byte width (header layout assumes 8)
// FIFO_DEPTH  32  entries per output FIFO, power of two >= 4
// TIMEOUT     30  idle cycles before unread-FIFO flush (SOFT_RESET_EN only)
// PORTS
// clock       in  1  single clock, rising edge
// resetn      in  1  synchronous, active-HIGH reset (port name kept as used by the codebase)
// pkt_valid   in  1  high during header+payload; low while the parity byte is presented
// data_in     in  8  header / payload / parity byte
// read_enb_0  in  1  pop FIFO 0 (same for _1, _2)
// data_out_0  out 8  FIFO 0 read data (same for _1, _2)
// vld_out_0   out 1  FIFO 0 non-empty (same for _1, _2)
// busy        out 1  source must hold data_in and pkt_valid while high
// err         out 1  parity mismatch on last packet
// BEHAVIOUR
// - Header: [7:2] payload length (informational; pkt_valid delimits the packet), [1:0] dest 0..2; 3 = invalid.
// - Input FSM states DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, LOAD_PARITY, CHECK_PARITY, DROP.
// - DECODE (busy=0): on edge with pkt_valid=1: dest 3 -> DROP; dest FIFO empty -> latch dest, header
//   accepted, -> LOAD_FIRST; else -> WAIT_EMPTY (busy=1) until that FIFO empty, then header accepted -> LOAD_FIRST.
// - LOAD_FIRST: busy=1 for exactly one cycle; header written to FIFO; data_in ignored; -> LOAD_DATA.
// - LOAD_DATA: busy = target FIFO full. If not full: pkt_valid=1 -> payload byte written;
//   pkt_valid=0 -> data_in is parity, written, -> LOAD_PARITY.
// - LOAD_PARITY: busy=1 one cycle; -> CHECK_PARITY. CHECK_PARITY: busy=1 one cycle; err<=(XOR of all
//   accepted bytes incl. parity != 0); -> DECODE.
// - DROP: busy=0, bytes discarded until pkt_valid=0 edge (parity discarded) -> DECODE; err unchanged.
// - err cleared when next header accepted; otherwise held.
// - Write latency: byte accepted on edge N visible as vld_out high after edge N (registered empty flag).
// - Read: edge with read_enb_x=1 and FIFO non-empty -> data_out_x <= head, pointer advances; read of
//   empty FIFO ignored, data_out_x holds. data_out_x otherwise holds last value.
// - vld_out_x = ~empty_x. Simultaneous read+write on one FIFO legal, count unchanged. Full: write
//   impossible (busy holds source); pointers wrap modulo FIFO_DEPTH.
// - FIFO instances named FIFO_0/FIFO_1/FIFO_2, each with an internal signal "empty" (bench probes it).
// - Reset (any time, incl. mid-packet): FSM -> DECODE, all FIFOs empty, data_out_x=0, vld_out_x=0,
//   busy=0, err=0, partial packet discarded.
// CONFIGURATION
// SOFT_RESET_EN defined: per FIFO, counter counts cycles with vld_out_x=1 and read_enb_x=0; reaching
//   TIMEOUT flushes that FIFO (empty next cycle), counter clears on any read or empty. If the input FSM
//   is writing that FIFO, the rest of that packet is discarded (treated as DROP).
// SOFT_RESET_EN undefined: no timeout; data stays until read.
// TESTING
// - Reset, header 0x16 (len 5, dest 2), 5 payload, parity -> FIFO_2 holds 7 bytes, vld_out_2=1, err=0;
//   read_enb_2 drains header first, then payload, parity; vld_out_2 falls after 7th read.
// - Header 0x39 (len 14, dest 1), 14 payload, good parity -> 16 bytes in FIFO_1 in order, err=0.
// - Header 0x40 (len 16, dest 0), 16 payload -> 18 bytes in FIFO_0, busy only in LOAD_FIRST/parity cycles.
// - Corrupt parity byte (xor 0x01) -> err=1 after CHECK_PARITY, cleared on next accepted header.
// - Header dest 3 -> no vld_out rises, busy=0 throughout, next valid packet routed normally.
// - FIFO_DEPTH=4, long packet, no reads -> busy=1 when full; enable reads -> busy drops, no byte lost.

Source files
------------

// File: rtl/router_1x3_top_if.sv
// Bundles the router's packet-input and three read-port signals.
//   pkt_valid, data_in        : packet source -> router
//   busy, err                 : router -> packet source
//   read_enb_0..2             : reader -> router (pop request per FIFO)
//   data_out_0..2, vld_out_0..2 : router -> reader
// master : the packet source / reader side. slave : the router.
interface router_1x3_top_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  busy;
  logic                  err;
  logic                  read_enb_0;
  logic                  read_enb_1;
  logic                  read_enb_2;
  logic [DATA_WIDTH-1:0] data_out_0;
  logic [DATA_WIDTH-1:0] data_out_1;
  logic [DATA_WIDTH-1:0] data_out_2;
  logic                  vld_out_0;
  logic                  vld_out_1;
  logic                  vld_out_2;

  modport master (
    output pkt_valid, data_in, read_enb_0, read_enb_1, read_enb_2,
    input  busy, err, data_out_0, data_out_1, data_out_2,
           vld_out_0, vld_out_1, vld_out_2
  );

  modport slave (
    input  pkt_valid, data_in, read_enb_0, read_enb_1, read_enb_2,
    output busy, err, data_out_0, data_out_1, data_out_2,
           vld_out_0, vld_out_1, vld_out_2
  );
endinterface

// File: rtl/router_1x3_top.sv
// 1-input, 3-output byte packet router.
// Packets {header, payload..., parity} arrive on bus.data_in and are stored
// whole in output FIFO header[1:0] (dest 3 is dropped). Each FIFO is read
// through read_enb_x / data_out_x / vld_out_x. busy throttles the source,
// err flags a parity mismatch on the last routed packet.
// Ports:
//   clock  : rising-edge clock
//   resetn : synchronous, active-HIGH reset
//   bus    : router_1x3_top_if.slave (packet input, status, three read ports)
// Build option: define SOFT_RESET_EN to flush a FIFO left unread for TIMEOUT
// cycles; without it data stays until read.

module router_1x3_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [AW:0]           count_next;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign do_wr = wr_en & ~full & ~flush;
  assign do_rd = rd_en & ~empty;

  always_comb begin
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // empty is registered so a byte written on edge N shows as valid after N.
  always_ff @(posedge clock) begin
    if (resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        empty  <= 1'b1;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + AW'(1);
        if (do_rd) rd_ptr <= rd_ptr + AW'(1);
        count <= count_next;
        empty <= (count_next == '0);
      end
      if (do_rd) rd_data <= mem[rd_ptr];
    end
  end
endmodule

module router_1x3_top #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int TIMEOUT    = 30
) (
  input  logic             clock,
  input  logic             resetn,
  router_1x3_top_if.slave  bus
);
  typedef enum logic [2:0] {
    DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, LOAD_PARITY, CHECK_PARITY, DROP
  } state_t;

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("router_1x3_top: FIFO_DEPTH must be a power of two >= 4 and TIMEOUT >= 1");
  end

  state_t                state;
  state_t                state_next;
  logic [1:0]            dest;
  logic [DATA_WIDTH-1:0] hdr;
  logic [DATA_WIDTH-1:0] parity;
  logic                  err;
  logic                  busy;
  logic                  latch_hdr;
  logic                  accept_hdr;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [2:0]            fifo_empty;
  logic [2:0]            fifo_full;
  logic [2:0]            fifo_wr;
  logic [2:0]            fifo_rd;
  logic [2:0]            soft_rst;
  logic                  cur_full;
  logic                  soft_hit;

  assign cur_full = fifo_full[dest];
  assign soft_hit = soft_rst[dest];

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    latch_hdr  = 1'b0;
    accept_hdr = 1'b0;
    wr         = 1'b0;
    wr_data    = bus.data_in;
    case (state)
      DECODE: begin
        // Header is latched here even when the target is busy, since the
        // source moves on to the first payload byte after this edge.
        if (bus.pkt_valid) begin
          if (bus.data_in[1:0] == 2'd3) begin
            state_next = DROP;
          end else begin
            latch_hdr = 1'b1;
            if (fifo_empty[bus.data_in[1:0]]) begin
              accept_hdr = 1'b1;
              state_next = LOAD_FIRST;
            end else begin
              state_next = WAIT_EMPTY;
            end
          end
        end
      end
      WAIT_EMPTY: begin
        busy = 1'b1;
        if (fifo_empty[dest]) begin
          accept_hdr = 1'b1;
          state_next = LOAD_FIRST;
        end
      end
      LOAD_FIRST: begin
        busy = 1'b1;
        if (soft_hit) begin
          state_next = DROP;
        end else begin
          wr         = 1'b1;
          wr_data    = hdr;
          state_next = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        // A flush of the target FIFO abandons the rest of the packet.
        if (soft_hit) begin
          state_next = bus.pkt_valid ? DROP : DECODE;
        end else begin
          busy = cur_full;
          if (!cur_full) begin
            wr = 1'b1;
            if (!bus.pkt_valid) state_next = LOAD_PARITY;
          end
        end
      end
      LOAD_PARITY: begin
        busy       = 1'b1;
        state_next = CHECK_PARITY;
      end
      CHECK_PARITY: begin
        busy       = 1'b1;
        state_next = DECODE;
      end
      DROP: begin
        if (!bus.pkt_valid) state_next = DECODE;
      end
      default: state_next = DECODE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state  <= DECODE;
      dest   <= '0;
      hdr    <= '0;
      parity <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_next;
      if (latch_hdr) begin
        dest   <= bus.data_in[1:0];
        hdr    <= bus.data_in;
        parity <= bus.data_in;
      end else if (state == LOAD_DATA && wr) begin
        parity <= parity ^ bus.data_in;
      end
      if (accept_hdr) err <= 1'b0;
      else if (state == CHECK_PARITY) err <= (parity != '0);
    end
  end

  assign fifo_wr[0] = wr & (dest == 2'd0);
  assign fifo_wr[1] = wr & (dest == 2'd1);
  assign fifo_wr[2] = wr & (dest == 2'd2);
  assign fifo_rd    = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};

`ifdef SOFT_RESET_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer [3];

  // Counts cycles a FIFO holds data without being read.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (resetn || fifo_empty[i] || fifo_rd[i] || soft_rst[i]) timer[i] <= '0;
      else timer[i] <= timer[i] + TW'(1);
    end
  end

  always_comb begin
    soft_rst = '0;
    for (int unsigned i = 0; i < 3; i++) soft_rst[i] = (timer[i] == TW'(TIMEOUT));
  end
`else
  assign soft_rst = '0;
`endif

  router_1x3_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) FIFO_0 (
    .clock(clock), .resetn(resetn), .flush(soft_rst[0]), .wr_en(fifo_wr[0]),
    .wr_data(wr_data), .rd_en(fifo_rd[0]), .rd_data(bus.data_out_0),
    .empty(fifo_empty[0]), .full(fifo_full[0])
  );

  router_1x3_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) FIFO_1 (
    .clock(clock), .resetn(resetn), .flush(soft_rst[1]), .wr_en(fifo_wr[1]),
    .wr_data(wr_data), .rd_en(fifo_rd[1]), .rd_data(bus.data_out_1),
    .empty(fifo_empty[1]), .full(fifo_full[1])
  );

  router_1x3_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) FIFO_2 (
    .clock(clock), .resetn(resetn), .flush(soft_rst[2]), .wr_en(fifo_wr[2]),
    .wr_data(wr_data), .rd_en(fifo_rd[2]), .rd_data(bus.data_out_2),
    .empty(fifo_empty[2]), .full(fifo_full[2])
  );

  assign bus.vld_out_0 = ~fifo_empty[0];
  assign bus.vld_out_1 = ~fifo_empty[1];
  assign bus.vld_out_2 = ~fifo_empty[2];
  assign bus.busy      = busy;
  assign bus.err       = err;
endmodule

// File: tb/tb_router_1x3_top.sv
// Directed bench for router_1x3_top: default-depth instance plus a
// FIFO_DEPTH=4 instance for the full/back-pressure case.
module tb_router_1x3_top;
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  router_1x3_top_if bus ();
  router_1x3_top_if bus4 ();

  router_1x3_top dut (.clock(clock), .resetn(resetn), .bus(bus.slave));
  router_1x3_top #(.FIFO_DEPTH(4)) dut4 (.clock(clock), .resetn(resetn), .bus(bus4.slave));

  int vectors = 0;
  int miscompares = 0;
  int busy_waits = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q4[$];
  logic [7:0] last_out [3];
  logic       exp_err [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input bit s, input logic [1:0] d, input logic [7:0] b);
    if (s) q4.push_back(b);
    else if (d == 2'd0) q0.push_back(b);
    else if (d == 2'd1) q1.push_back(b);
    else q2.push_back(b);
  endfunction

  function automatic int qsize(input int unsigned d);
    return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
  endfunction

  function automatic logic [7:0] pop(input int unsigned d);
    if (qsize(d) == 0) return 8'hxx;
    return (d == 0) ? q0.pop_front() : (d == 1) ? q1.pop_front() : q2.pop_front();
  endfunction

  function automatic logic vld(input int unsigned d);
    return (d == 0) ? bus.vld_out_0 : (d == 1) ? bus.vld_out_1 : bus.vld_out_2;
  endfunction

  function automatic logic [7:0] dout(input int unsigned d);
    return (d == 0) ? bus.data_out_0 : (d == 1) ? bus.data_out_1 : bus.data_out_2;
  endfunction

  task automatic set_re(input int unsigned d, input logic v);
    if (d == 0) bus.read_enb_0 = v;
    else if (d == 1) bus.read_enb_1 = v;
    else bus.read_enb_2 = v;
  endtask

  // Presents one byte and holds it until an edge where busy was low.
  task automatic drive_byte(input bit s, input logic pv, input logic [7:0] d);
    logic bz;
    int unsigned t;
    @(negedge clock);
    if (s) begin bus4.pkt_valid = pv; bus4.data_in = d; end
    else begin bus.pkt_valid = pv; bus.data_in = d; end
    t = 0;
    forever begin
      bz = s ? bus4.busy : bus.busy;
      @(posedge clock);
      if (!bz) break;
      busy_waits++;
      t++;
      if (t > 500) begin
        vectors++;
        miscompares++;
        $error("FAIL busy_timeout: observed busy held %0d cycles required release", t);
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic send_pkt(input bit s, input logic [7:0] hdr, input int unsigned n,
                          input bit bad, input int exp_waits);
    logic [7:0] par;
    logic [7:0] b;
    logic [1:0] d;
    d = hdr[1:0];
    par = hdr;
    busy_waits = 0;
    if (d != 2'd3) push(s, d, hdr);
    drive_byte(s, 1'b1, hdr);
    #1;
    if (d != 2'd3) exp_err[s] = 1'b0;
    check("err_after_hdr", s ? bus4.err : bus.err, exp_err[s]);
    for (int unsigned i = 0; i < n; i++) begin
      b = 8'($urandom);
      par ^= b;
      if (d != 2'd3) push(s, d, b);
      drive_byte(s, 1'b1, b);
    end
    if (bad) par ^= 8'h01;
    if (d != 2'd3) push(s, d, par);
    drive_byte(s, 1'b0, par);
    @(negedge clock);
    if (s) begin bus4.pkt_valid = 1'b0; bus4.data_in = '0; end
    else begin bus.pkt_valid = 1'b0; bus.data_in = '0; end
    @(posedge clock);
    @(posedge clock);
    #1;
    if (d != 2'd3) exp_err[s] = bad;
    check("err_after_pkt", s ? bus4.err : bus.err, exp_err[s]);
    if (exp_waits >= 0) check("busy_waits", busy_waits, exp_waits);
  endtask

  task automatic drain(input int unsigned d, input int unsigned n);
    logic [7:0] e;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clock);
      check("vld_before_read", vld(d), 32'(qsize(d) != 0));
      set_re(d, 1'b1);
      @(posedge clock);
      #1;
      e = pop(d);
      last_out[d] = e;
      check("data_out", dout(d), e);
    end
    @(negedge clock);
    set_re(d, 1'b0);
    check("vld_after_drain", vld(d), 32'(qsize(d) != 0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    logic v;
    int unsigned got;
    int unsigned cyc;
    bus.pkt_valid = 1'b0;  bus.data_in = '0;
    bus.read_enb_0 = 1'b0; bus.read_enb_1 = 1'b0; bus.read_enb_2 = 1'b0;
    bus4.pkt_valid = 1'b0; bus4.data_in = '0;
    bus4.read_enb_0 = 1'b0; bus4.read_enb_1 = 1'b0; bus4.read_enb_2 = 1'b0;
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
    last_out[0] = '0; last_out[1] = '0; last_out[2] = '0;

    resetn = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    check("rst_vld0", bus.vld_out_0, 0);
    check("rst_vld1", bus.vld_out_1, 0);
    check("rst_vld2", bus.vld_out_2, 0);
    check("rst_dout0", bus.data_out_0, 0);
    check("rst_dout2", bus.data_out_2, 0);
    check("rst_fifo0_empty", dut.FIFO_0.empty, 1);
    check("rst_busy4", bus4.busy, 0);

    // len 5 to dest 2: header, payload, parity drained in order
    send_pkt(1'b0, 8'h16, 5, 1'b0, 1);
    check("p1_vld2", bus.vld_out_2, 1);
    check("p1_fifo2_empty", dut.FIFO_2.empty, 0);
    check("p1_vld0_idle", bus.vld_out_0, 0);
    drain(2, 7);
    // read of an empty FIFO keeps the last data
    @(negedge clock);
    set_re(2, 1'b1);
    @(posedge clock);
    #1;
    check("rd_empty_hold", bus.data_out_2, last_out[2]);
    check("rd_empty_vld", bus.vld_out_2, 0);
    @(negedge clock);
    set_re(2, 1'b0);

    send_pkt(1'b0, 8'h39, 14, 1'b0, 1);
    drain(1, 16);

    send_pkt(1'b0, 8'h40, 16, 1'b0, 1);
    drain(0, 18);

    // corrupted parity, then a dropped packet leaves err set
    send_pkt(1'b0, 8'h0C, 3, 1'b1, 1);
    drain(0, 5);
    send_pkt(1'b0, 8'h13, 4, 1'b0, 0);
    check("drop_vld0", bus.vld_out_0, 0);
    check("drop_vld1", bus.vld_out_1, 0);
    check("drop_vld2", bus.vld_out_2, 0);
    // next accepted header clears err
    send_pkt(1'b0, 8'h0A, 2, 1'b0, 1);
    drain(2, 4);

    // depth-4 instance: source stalls on full FIFO, no byte lost once read
    fork
      send_pkt(1'b1, 8'h40, 16, 1'b0, -1);
      begin
        repeat (20) @(negedge clock);
        check("d4_busy_full", bus4.busy, 1);
        check("d4_vld0", bus4.vld_out_0, 1);
        check("d4_fifo0_empty", dut4.FIFO_0.empty, 0);
        bus4.read_enb_0 = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 18 && cyc < 600) begin
          v = bus4.vld_out_0;
          @(posedge clock);
          #1;
          if (v) begin
            e = (q4.size() != 0) ? q4.pop_front() : 8'hxx;
            check("d4_data", bus4.data_out_0, e);
            got++;
          end
          @(negedge clock);
          cyc++;
        end
        bus4.read_enb_0 = 1'b0;
        check("d4_all_read", got, 18);
      end
    join
    check("d4_busy_idle", bus4.busy, 0);
    check("d4_q_empty", q4.size(), 0);

    // reset in the middle of a packet discards it
    drive_byte(1'b0, 1'b1, 8'h16);
    drive_byte(1'b0, 1'b1, 8'hA5);
    drive_byte(1'b0, 1'b1, 8'h5A);
    @(negedge clock);
    resetn = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.data_in = '0;
    @(posedge clock);
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_vld2", bus.vld_out_2, 0);
    check("midrst_dout2", bus.data_out_2, 0);
    check("midrst_err", bus.err, 0);
    @(negedge clock);
    resetn = 1'b0;
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
    send_pkt(1'b0, 8'h06, 1, 1'b0, 1);
    drain(2, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
